// File: rtl/dfr_batch_sequencer_if.sv
// Bundles the sequencer's host config/status, memory and DFR core signals.
// The master modport is the sequencer; the slave modport is the surrounding system.
interface dfr_batch_sequencer_if #(
  parameter int ADDR_W = 13,
  parameter int OUT_W  = 26
);
  logic              cfg_start;
  logic              cfg_abort;
  logic [ADDR_W:0]   cfg_num_samples;
  logic [ADDR_W-1:0] in_ram_addr;
  logic [31:0]       in_ram_rdata;
  logic              dfr_resetn;
  logic              dfr_start;
  logic              dfr_busy;
  logic              dfr_done;
  logic [15:0]       dfr_i_data;
  logic [15:0]       dfr_q_data;
  logic [OUT_W-1:0]  dfr_returndata;
  logic [ADDR_W-1:0] out_ram_addr;
  logic [OUT_W-1:0]  out_ram_wdata;
  logic              out_ram_wen;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_error;
  logic              seq_aborted;
  logic [ADDR_W:0]   samples_done;

  modport master (
    input  cfg_start, cfg_abort, cfg_num_samples, in_ram_rdata,
           dfr_busy, dfr_done, dfr_returndata,
    output in_ram_addr, dfr_resetn, dfr_start, dfr_i_data, dfr_q_data,
           out_ram_addr, out_ram_wdata, out_ram_wen,
           seq_busy, seq_done, seq_error, seq_aborted, samples_done
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_num_samples, in_ram_rdata,
           dfr_busy, dfr_done, dfr_returndata,
    input  in_ram_addr, dfr_resetn, dfr_start, dfr_i_data, dfr_q_data,
           out_ram_addr, out_ram_wdata, out_ram_wen,
           seq_busy, seq_done, seq_error, seq_aborted, samples_done
  );
endinterface

// File: rtl/dfr_batch_sequencer.sv
// Runs the DFR core once per input-RAM sample and stores each result in the output RAM.
// Owns the sample index, the core reset pulse and a per-sample watchdog.
module dfr_batch_sequencer #(
  parameter int ADDR_W         = 13,
  parameter int OUT_W          = 26,
  parameter int RESETN_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  dfr_batch_sequencer_if.master bus,
  output logic [2:0]            dbg_state
);
  localparam int CNT_MAX = (RESETN_CYCLES > TIMEOUT_CYCLES) ? RESETN_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESETN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]  N_MAX    = (ADDR_W + 1)'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IP_RST = 3'd1,
    S_FETCH  = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_FLUSH  = 3'd7
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   samples_q;
  logic [OUT_W-1:0]  result_q;
  logic [15:0]       i_q, q_q;
  logic              resetn_q, start_q, error_q, aborted_q;
  logic              abort_hit, timeout_hit, accept_start, last_sample;

  // Abort outranks done, timeout and write in the same cycle.
  assign abort_hit    = bus.cfg_abort && (state != S_IDLE) && (state != S_FLUSH);
  assign timeout_hit  = (state == S_WAIT) && !bus.dfr_done && (cnt == TO_LAST) && !abort_hit;
  assign accept_start = (state == S_IDLE) && bus.cfg_start;
  assign last_sample  = ({1'b0, idx} == (n_q - (ADDR_W + 1)'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:   if (bus.cfg_start)
                    next_state = (bus.cfg_num_samples == '0) ? S_DONE : S_IP_RST;
        S_IP_RST: if (cnt == RST_LAST) next_state = S_FETCH;
        S_FETCH:  next_state = S_LAUNCH;
        S_LAUNCH: if (!bus.dfr_busy) next_state = S_WAIT;
        S_WAIT:   if (bus.dfr_done)  next_state = S_WRITE;
                  else if (timeout_hit) next_state = S_FLUSH;
        S_WRITE:  next_state = last_sample ? S_DONE : S_FETCH;
        S_DONE:   next_state = S_IDLE;
        S_FLUSH:  if (cnt == RST_LAST) next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.seq_busy    = (state != S_IDLE);
    bus.seq_done    = (state == S_DONE) && !abort_hit;
    bus.out_ram_wen = (state == S_WRITE) && !abort_hit;
    dbg_state       = state;
  end

  assign bus.in_ram_addr   = idx;
  assign bus.out_ram_addr  = idx;
  assign bus.out_ram_wdata = result_q;
  assign bus.dfr_i_data    = i_q;
  assign bus.dfr_q_data    = q_q;
  assign bus.dfr_resetn    = resetn_q;
  assign bus.dfr_start     = start_q;
  assign bus.seq_error     = error_q;
  assign bus.seq_aborted   = aborted_q;
  assign bus.samples_done  = samples_q;

  // Core reset and start are registered from the next state so the start pulse
  // lines up with the I/Q registers captured during LAUNCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      n_q       <= '0;
      samples_q <= '0;
      result_q  <= '0;
      i_q       <= '0;
      q_q       <= '0;
      resetn_q  <= 1'b0;
      start_q   <= 1'b0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      resetn_q <= !((next_state == S_IP_RST) || (next_state == S_FLUSH));
      start_q  <= (state == S_LAUNCH) && (next_state == S_WAIT);
      if ((next_state == state) &&
          ((state == S_IP_RST) || (state == S_FLUSH) || (state == S_WAIT)))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      if (accept_start) begin
        n_q       <= (bus.cfg_num_samples > N_MAX) ? N_MAX : bus.cfg_num_samples;
        idx       <= '0;
        samples_q <= '0;
        error_q   <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (state == S_LAUNCH) begin
        i_q <= bus.in_ram_rdata[31:16];
        q_q <= bus.in_ram_rdata[15:0];
      end
      if ((state == S_WAIT) && bus.dfr_done && !abort_hit) result_q <= bus.dfr_returndata;
      if (timeout_hit) error_q   <= 1'b1;
      if (abort_hit)   aborted_q <= 1'b1;
      if (bus.out_ram_wen) begin
        samples_q <= samples_q + (ADDR_W + 1)'(1);
        if (!last_sample) idx <= idx + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_dfr_batch_sequencer.sv
// Directed bench for dfr_batch_sequencer with an input-RAM model and a DFR core model
// whose result is I+Q; expected results are hand-computed constants.
module tb_dfr_batch_sequencer;
  localparam int ADDR_W = 13;
  localparam int OUT_W  = 26;

  logic clk;
  logic reset;
  logic [2:0] dbg_state;

  dfr_batch_sequencer_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  dfr_batch_sequencer #(
    .ADDR_W(ADDR_W), .OUT_W(OUT_W), .RESETN_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int core_lat = 5;
  bit core_hang = 1'b0;

  // Input RAM: word at address a is {16'h1000+a, 16'h2000+a}, one cycle read latency.
  always @(posedge clk)
    bus.in_ram_rdata <= {16'h1000 + 16'(bus.in_ram_addr), 16'h2000 + 16'(bus.in_ram_addr)};

  // Core model: returns I+Q a fixed number of cycles after dfr_start.
  int   core_cnt;
  bit   core_pend;
  logic [15:0] core_i, core_q;
  always @(posedge clk) begin
    if (bus.dfr_resetn !== 1'b1) begin
      core_pend     <= 1'b0;
      bus.dfr_done  <= 1'b0;
    end else begin
      bus.dfr_done <= 1'b0;
      if (bus.dfr_start) begin
        core_pend <= 1'b1;
        core_cnt  <= core_lat - 1;
        core_i    <= bus.dfr_i_data;
        core_q    <= bus.dfr_q_data;
      end else if (core_pend && !core_hang) begin
        if (core_cnt == 0) begin
          bus.dfr_done       <= 1'b1;
          bus.dfr_returndata <= OUT_W'({1'b0, core_i} + {1'b0, core_q});
          core_pend          <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // Event monitor: captured output writes and pulse counters.
  logic [ADDR_W-1:0] wr_addr [0:255];
  logic [OUT_W-1:0]  wr_data [0:255];
  int wr_count = 0, start_cnt = 0, done_cnt = 0, rstn_low_cnt = 0;
  always @(posedge clk) begin
    if (bus.out_ram_wen === 1'b1 && wr_count < 256) begin
      wr_addr[wr_count] <= bus.out_ram_addr;
      wr_data[wr_count] <= bus.out_ram_wdata;
      wr_count <= wr_count + 1;
    end
    if (bus.dfr_start === 1'b1)  start_cnt    <= start_cnt + 1;
    if (bus.seq_done === 1'b1)   done_cnt     <= done_cnt + 1;
    if (bus.dfr_resetn !== 1'b1) rstn_low_cnt <= rstn_low_cnt + 1;
  end

  logic [OUT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_seq_done(input string tag, input int budget);
    int n = 0;
    while (bus.seq_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.seq_done), 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(st));
  endtask

  task automatic pulse_start(input int num);
    bus.cfg_num_samples = (ADDR_W + 1)'(num);
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  // Compares writes captured from index base against exp_q, addresses counting from 0.
  task automatic check_writes(input string tag, input int base);
    int n = exp_q.size();
    check({tag, "_count"}, 32'(wr_count - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [OUT_W-1:0] e = exp_q.pop_front();
      check({tag, "_addr"}, 32'(wr_addr[base + i]), 32'(i));
      check({tag, "_data"}, 32'(wr_data[base + i]), 32'(e));
    end
  endtask

  int w_base, s_base, d_base, r_base;
  int cyc, bad, seen;

  initial begin
    reset = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    bus.cfg_num_samples = '0;
    bus.dfr_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resetn",   32'(bus.dfr_resetn), 0);
    check("rst_busy",     32'(bus.seq_busy), 0);
    check("rst_samples",  32'(bus.samples_done), 0);
    check("rst_wen",      32'(bus.out_ram_wen), 0);
    check("rst_flags",    {30'b0, bus.seq_error, bus.seq_aborted}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_resetn",  32'(bus.dfr_resetn), 1);
    check("idle_state",   32'(dbg_state), 0);

    // 1: three samples, core latency 5
    w_base = wr_count; s_base = start_cnt; d_base = done_cnt; r_base = rstn_low_cnt;
    pulse_start(3);
    check("t1_busy", 32'(bus.seq_busy), 1);
    wait_seq_done("t1_done_seen", 200);
    @(negedge clk);
    exp_q.push_back(26'h0003000); exp_q.push_back(26'h0003002); exp_q.push_back(26'h0003004);
    check_writes("t1_wr", w_base);
    check("t1_samples", 32'(bus.samples_done), 3);
    check("t1_done_cnt", 32'(done_cnt - d_base), 1);
    check("t1_starts", 32'(start_cnt - s_base), 3);
    check("t1_rstn_low", 32'(rstn_low_cnt - r_base), 4);
    check("t1_idle", 32'(bus.seq_busy), 0);

    // 2: empty batch
    w_base = wr_count; s_base = start_cnt; d_base = done_cnt; r_base = rstn_low_cnt;
    pulse_start(0);
    check("t2_done_now", 32'(bus.seq_done), 1);
    @(negedge clk);
    check("t2_done_gone", 32'(bus.seq_done), 0);
    check("t2_idle", 32'(bus.seq_busy), 0);
    check("t2_starts", 32'(start_cnt - s_base), 0);
    check("t2_writes", 32'(wr_count - w_base), 0);
    check("t2_rstn_low", 32'(rstn_low_cnt - r_base), 0);
    check("t2_done_cnt", 32'(done_cnt - d_base), 1);
    check("t2_samples", 32'(bus.samples_done), 0);

    // 3: core busy for 10 cycles in LAUNCH
    w_base = wr_count;
    bus.dfr_busy = 1'b1;
    pulse_start(1);
    wait_state("t3_launch", 3'd3, 50);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.dfr_start !== 1'b0) bad++;
      if (i > 0 && (bus.dfr_i_data !== 16'h1000 || bus.dfr_q_data !== 16'h2000)) bad++;
      if (dbg_state !== 3'd3) bad++;
      @(negedge clk);
    end
    check("t3_stall_cycles_bad", 32'(bad), 0);
    bus.dfr_busy = 1'b0;
    @(negedge clk);
    check("t3_start_after_busy", 32'(bus.dfr_start), 1);
    check("t3_iq", {bus.dfr_i_data, bus.dfr_q_data}, 32'h1000_2000);
    @(negedge clk);
    check("t3_start_single", 32'(bus.dfr_start), 0);
    wait_seq_done("t3_done_seen", 100);
    @(negedge clk);
    exp_q.push_back(26'h0003000);
    check_writes("t3_wr", w_base);

    // 4: core never answers; watchdog of 16 cycles
    w_base = wr_count; d_base = done_cnt;
    core_hang = 1'b1;
    pulse_start(2);
    cyc = 0;
    while (bus.dfr_start !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    check("t4_start_seen", 32'(bus.dfr_start), 1);
    cyc = 0;
    while (dbg_state === 3'd4 && cyc < 100) begin @(negedge clk); cyc++; end
    check("t4_wait_cycles", 32'(cyc), 16);
    check("t4_error", 32'(bus.seq_error), 1);
    cyc = 0;
    while (bus.dfr_resetn !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    check("t4_flush_rstn_low", 32'(cyc), 4);
    check("t4_state_idle", 32'(dbg_state), 0);
    check("t4_no_done", 32'(done_cnt - d_base), 0);
    check("t4_no_writes", 32'(wr_count - w_base), 0);
    check("t4_not_aborted", 32'(bus.seq_aborted), 0);
    core_hang = 1'b0;

    // 5: abort coincident with dfr_done on sample 1 of 4
    w_base = wr_count; d_base = done_cnt;
    pulse_start(4);
    check("t5_error_cleared", 32'(bus.seq_error), 0);
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 200) begin
      if (bus.dfr_done === 1'b1) seen++;
      if (seen < 2) begin @(negedge clk); cyc++; end
    end
    check("t5_second_done_seen", 32'(seen), 2);
    bus.cfg_abort = 1'b1;
    @(negedge clk);
    bus.cfg_abort = 1'b0;
    check("t5_flush", 32'(dbg_state), 7);
    check("t5_aborted", 32'(bus.seq_aborted), 1);
    wait_state("t5_back_idle", 3'd0, 50);
    exp_q.push_back(26'h0003000);
    check_writes("t5_wr", w_base);
    check("t5_samples", 32'(bus.samples_done), 1);
    check("t5_no_done", 32'(done_cnt - d_base), 0);

    // 6: start while busy is ignored; a fresh batch clears sticky flags
    w_base = wr_count; d_base = done_cnt;
    pulse_start(2);
    check("t6_aborted_cleared", 32'(bus.seq_aborted), 0);
    repeat (3) @(negedge clk);
    pulse_start(5);
    wait_seq_done("t6_done_seen", 200);
    @(negedge clk);
    exp_q.push_back(26'h0003000); exp_q.push_back(26'h0003002);
    check_writes("t6_wr", w_base);
    check("t6_samples", 32'(bus.samples_done), 2);
    check("t6_done_cnt", 32'(done_cnt - d_base), 1);
    w_base = wr_count;
    pulse_start(1);
    wait_seq_done("t6b_done_seen", 100);
    @(negedge clk);
    exp_q.push_back(26'h0003000);
    check_writes("t6b_wr", w_base);
    check("t6b_samples", 32'(bus.samples_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
